// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding register.
//
// Sends 1 start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. The holding register lets the host queue the next character
// while the current one shifts out, so frames can go back-to-back with no idle gap
// beyond the stop bits. Bit timing comes from an external one-cycle baud strobe.
//
// Parameters:
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame, 1 or 2
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   baud      one-cycle baud enable strobe (one bit period per strobe)
//   txdata    character to send, bit 0 first
//   tx_valid  host offers txdata this cycle
//   tx_ready  holding register empty; transfer on tx_valid && tx_ready
//   tx        serial output, idle high
//   busy      frame in progress
//   tx_done   one-cycle pulse after the final stop bit period is issued

module uart_tx_frame #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] txdata,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned MaxBits = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned CntW    = (MaxBits > 1) ? $clog2(MaxBits) : 1;

    localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);
    localparam logic            OddPar   = (PARITY == 2);
    localparam logic            HasPar   = (PARITY != 0);

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_frame: illegal DATA_BITS/PARITY/STOP_BITS combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_valid;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [CntW-1:0]      cnt;

    // Ready depends only on the holding register, never on tx_valid.
    assign tx_ready = !hold_valid;
    assign busy     = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            par_bit    <= 1'b0;
            cnt        <= '0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Host handshake. Cannot collide with the IDLE hand-off below, since
            // that only fires while hold_valid is set (tx_ready low).
            if (tx_valid && !hold_valid) begin
                hold       <= txdata;
                hold_valid <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    // Hand-off needs no baud strobe; baud is ignored while idle.
                    if (hold_valid) begin
                        shift      <= hold;
                        par_bit    <= (^hold) ^ OddPar;
                        hold_valid <= 1'b0;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    if (baud) begin
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= StData;
                    end
                end
                StData: begin
                    if (baud) begin
                        tx    <= shift[0];
                        shift <= {1'b0, shift[DATA_BITS-1:1]};
                        if (cnt == LastData) begin
                            cnt   <= '0;
                            state <= HasPar ? StParity : StStop;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (baud) begin
                        tx    <= par_bit;
                        cnt   <= '0;
                        state <= StStop;
                    end
                end
                StStop: begin
                    if (baud) begin
                        tx <= 1'b1;
                        if (cnt == LastStop) begin
                            cnt     <= '0;
                            state   <= StIdle;
                            tx_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7O2) share clock,
// reset and baud. Expected serial bits are queued when a character is offered and
// popped as each baud-qualified edge produces a new line level.

module tb_uart_tx_frame;

    logic       clk;
    logic       reset;
    logic       baud;
    logic       baud_en;
    logic [3:0] valid;
    logic [7:0] d8 [3];
    logic [6:0] d7;
    logic [3:0] tx_w;
    logic [3:0] ready_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    logic [1:0] sel;
    logic       tx_m, ready_m, busy_m, done_m;
    assign tx_m    = tx_w[sel];
    assign ready_m = ready_w[sel];
    assign busy_m  = busy_w[sel];
    assign done_m  = done_w[sel];

    int   checks;
    int   failures;
    int   done_cnt [4];
    logic exp_q [$];
    logic prev_lvl;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .baud(baud), .txdata(d8[0]), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
    );
    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .baud(baud), .txdata(d8[1]), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
    );
    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .baud(baud), .txdata(d8[2]), .tx_valid(valid[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
    );
    uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .reset(reset), .baud(baud), .txdata(d7), .tx_valid(valid[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobe every 4 clocks, updated 2 time units after the rising edge.
    initial begin
        int ph;
        ph   = 0;
        baud = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph   = (ph + 1) % 4;
            baud = baud_en && (ph == 0);
        end
    end

    // Count cycles in which each tx_done is high.
    initial begin
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_w[i]) done_cnt[i]++;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int nb, input int par,
                              input int nstop);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 1) exp_q.push_back(p);
        else if (par == 2) exp_q.push_back(~p);
        for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
    endtask

    // Leave the bench 1 time unit after a baud-qualified edge.
    task automatic sync_baud(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 16 && !ok; t++) begin
            @(negedge clk);
            if (baud) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        chk(32'(ok), 1, {tag, "_sync"});
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        bit ok;
        ok = 1'b0;
        if (sel == 2'd3) d7 = d[6:0];
        else d8[sel] = d;
        valid[sel] = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (ready_m) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        valid[sel] = 1'b0;
        chk(32'(ok), 1, {tag, "_accept"});
    endtask

    // Wait for n bit periods; tx must hold between strobes and match the queue after.
    task automatic run_bits(input int n, input bit chk_first, input string tag);
        bit   ok;
        int   waited;
        logic e;
        for (int k = 0; k < n; k++) begin
            ok     = 1'b0;
            waited = 0;
            while (!ok && waited < 64) begin
                @(negedge clk);
                waited++;
                chk(32'(tx_m), 32'(prev_lvl), {tag, "_hold"});
                if (baud && busy_m) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end
            end
            chk(32'(ok), 1, {tag, "_timeout"});
            if (!ok) return;
            if (k > 0 || chk_first) chk(32'(waited), 4, {tag, "_period"});
            chk(32'(exp_q.size() > 0), 1, {tag, "_queue"});
            if (exp_q.size() == 0) return;
            e = exp_q.pop_front();
            chk(32'(tx_m), 32'(e), $sformatf("%s_bit%0d", tag, k));
            prev_lvl = e;
        end
    endtask

    task automatic end_frames(input int n_frames, input int base, input string tag);
        chk(32'(done_m), 1, {tag, "_done"});
        chk(32'(busy_m), 0, {tag, "_busy_fall"});
        @(posedge clk);
        #1;
        chk(32'(done_m), 0, {tag, "_done_pulse"});
        chk(32'(done_cnt[sel] - base), 32'(n_frames), {tag, "_done_count"});
        chk(32'(exp_q.size()), 0, {tag, "_queue_empty"});
    endtask

    initial begin
        int base;
        int acc_total;
        int acc_idle;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        baud_en  = 1'b1;
        valid    = 4'b0000;
        for (int i = 0; i < 3; i++) d8[i] = 8'h00;
        d7       = 7'h00;
        sel      = 2'd0;
        prev_lvl = 1'b1;

        // Reset, with tx_valid offered while reset is high.
        valid[0] = 1'b1;
        d8[0]    = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk(32'(tx_w[i]), 1, $sformatf("rst_tx%0d", i));
            chk(32'(ready_w[i]), 1, $sformatf("rst_ready%0d", i));
            chk(32'(busy_w[i]), 0, $sformatf("rst_busy%0d", i));
            chk(32'(done_w[i]), 0, $sformatf("rst_done%0d", i));
        end
        valid[0] = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        chk(32'(ready_w[0]), 1, "rst_valid_ignored");
        chk(32'(busy_w[0]), 0, "rst_idle");

        // 8N1, 0x55.
        sel = 2'd0;
        sync_baud("n1");
        base = done_cnt[0];
        push_frame(8'h55, 8, 0, 1);
        send(8'h55, "n1");
        chk(32'(ready_m), 0, "n1_ready_full");
        chk(32'(busy_m), 0, "n1_busy_accept");
        @(posedge clk);
        #1;
        chk(32'(busy_m), 1, "n1_busy_start");
        chk(32'(ready_m), 1, "n1_ready_free");
        run_bits(10, 1'b0, "n1");
        end_frames(1, base, "n1");

        // 8E1 and 8O1, 0x07.
        sel = 2'd1;
        sync_baud("e1");
        base = done_cnt[1];
        push_frame(8'h07, 8, 1, 1);
        send(8'h07, "e1");
        run_bits(11, 1'b0, "e1");
        end_frames(1, base, "e1");

        sel = 2'd2;
        sync_baud("o1");
        base = done_cnt[2];
        push_frame(8'h07, 8, 2, 1);
        send(8'h07, "o1");
        run_bits(11, 1'b0, "o1");
        end_frames(1, base, "o1");

        // 7O2, 0x00: 11 periods.
        sel = 2'd3;
        sync_baud("o2");
        base = done_cnt[3];
        push_frame(8'h00, 7, 2, 2);
        send(8'h00, "o2");
        run_bits(11, 1'b0, "o2");
        end_frames(1, base, "o2");

        // Back-to-back 8N1 with tx_valid held: 0xA5 then 0x3C.
        sel = 2'd0;
        sync_baud("b2b");
        base = done_cnt[0];
        push_frame(8'hA5, 8, 0, 1);
        push_frame(8'h3C, 8, 0, 1);
        d8[0]    = 8'hA5;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        chk(32'(ready_m), 0, "b2b_acc1");
        d8[0] = 8'h3C;
        @(posedge clk);
        #1;
        chk(32'(ready_m), 1, "b2b_free");
        @(posedge clk);
        #1;
        chk(32'(ready_m), 0, "b2b_acc2");
        valid[0] = 1'b0;
        run_bits(5, 1'b0, "b2b");
        chk(32'(ready_m), 0, "b2b_ready_held");
        run_bits(15, 1'b1, "b2b");
        end_frames(2, base, "b2b");

        // Reset mid-DATA of 0xF0 with 0x99 held.
        sync_baud("rm");
        base = done_cnt[0];
        push_frame(8'hF0, 8, 0, 1);
        send(8'hF0, "rm_a");
        send(8'h99, "rm_b");
        run_bits(5, 1'b0, "rm");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(32'(tx_m), 1, "rm_tx");
        chk(32'(ready_m), 1, "rm_ready");
        chk(32'(busy_m), 0, "rm_busy");
        chk(32'(done_m), 0, "rm_done");
        reset = 1'b0;
        exp_q.delete();
        prev_lvl = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk(32'(busy_m), 0, "rm_discard_busy");
            chk(32'(tx_m), 1, "rm_discard_tx");
        end
        chk(32'(done_cnt[0] - base), 0, "rm_no_done");
        sync_baud("rm2");
        base = done_cnt[0];
        push_frame(8'h81, 8, 0, 1);
        send(8'h81, "rm2");
        run_bits(10, 1'b0, "rm2");
        end_frames(1, base, "rm2");

        // tx_valid held high with no baud strobes.
        sync_baud("nb");
        base      = done_cnt[0];
        baud_en   = 1'b0;
        acc_total = 0;
        acc_idle  = 0;
        d8[0]     = 8'h3C;
        valid[0]  = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk(32'(tx_m), 1, "nb_tx_idle");
            if (valid[0] && ready_m) begin
                acc_total++;
                if (!busy_m) acc_idle++;
            end
        end
        valid[0] = 1'b0;
        chk(32'(acc_idle), 1, "nb_idle_accepts");
        chk(32'(acc_total), 2, "nb_total_accepts");
        push_frame(8'h3C, 8, 0, 1);
        push_frame(8'h3C, 8, 0, 1);
        baud_en = 1'b1;
        run_bits(20, 1'b0, "nb");
        end_frames(2, base, "nb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
